tcdm_mux_rr: RTL and testbench
==============================

Name: tcdm_mux_rr

Overview:
- Parametrised N-to-1 TCDM multiplexer: NumIn TCDM master ports share one TCDM slave port.
- Arbitration is round-robin. Each granted request's source index is stored in an in-order ID FIFO, and every slave response is routed back to the master that issued it.
- Supports multiple outstanding transactions (MaxOutstanding) with configurable address/data widths.
- Sits between cluster-side TCDM masters (cores, DMA, accelerator streamers) and a single memory bank port.

Parameters:
- NumIn, 4, number of master ports (>=2).
- AddrWidth, 32, address width.
- DataWidth, 32, data width; multiple of 8.
- BeWidth, DataWidth/8, byte-enable width (derived; do not override).
- MaxOutstanding, 4, depth of ID FIFO = max in-flight requests (>=1).

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset, synchronous, active-high.
- in_req_i  in  NumIn  per-master request.
- in_add_i  in  NumIn*AddrWidth  per-master address.
- in_wen_i  in  NumIn  per-master write-enable-n (1=read).
- in_wdata_i  in  NumIn*DataWidth  per-master write data.
- in_be_i  in  NumIn*BeWidth  per-master byte enables.
- in_gnt_o  out  NumIn  per-master grant.
- in_r_rdata_o  out  NumIn*DataWidth  per-master response data.
- in_r_opc_o  out  NumIn  per-master response error.
- in_r_valid_o  out  NumIn  per-master response valid.
- out_req_o  out  1  slave request.
- out_add_o  out  AddrWidth  slave address.
- out_wen_o  out  1  slave wen.
- out_wdata_o  out  DataWidth  slave write data.
- out_be_o  out  BeWidth  slave byte enables.
- out_gnt_i  in  1  slave grant.
- out_r_rdata_i  in  DataWidth  slave response data.
- out_r_opc_i  in  1  slave response error.
- out_r_valid_i  in  1  slave response valid.
- err_o  out  1  sticky: response received with no outstanding request.

Behaviour:
- One clock, clk_i. Reset rst_i is synchronous and active-high.
- Reset values:
  - RR pointer = 0; FIFO empty (count 0); err_o = 0.
  - All in_gnt_o / in_r_valid_o / in_r_opc_o = 0 while rst_i is high.
  - out_req_o = 0 while rst_i is high.
- Request path is combinational (0-cycle latency).
  - sel = first index with in_req_i set, searching from ptr upward with wrap at NumIn.
  - out_req_o = |in_req_i & !full.
  - out_add/wen/wdata/be = fields of sel.
  - in_gnt_o[sel] = out_gnt_i & out_req_o; all other grants are 0.
- Handshake = out_req_o & out_gnt_i. On a handshake:
  - push sel into the FIFO;
  - ptr <= (sel+1) mod NumIn.
  - ptr does not change without a handshake.
- sel may change between cycles while un-granted (TCDM allows it). Masters must hold req/fields until granted.
- Full (count==MaxOutstanding):
  - out_req_o forced 0, no grants.
  - Applies even if a response pops in the same cycle (conservative; no push-on-pop when full).
- Response path is combinational from the FIFO head.
  - When out_r_valid_i and count>0:
    - in_r_valid_o[head] = 1;
    - in_r_rdata_o and in_r_opc_o slices for head carry the slave values;
    - pop the FIFO.
  - Non-selected r_valid = 0. Rdata slices of all ports = out_r_rdata_i (broadcast); opc gated by head.
- Responses are assumed in order (single slave port); no reordering.
- Simultaneous push and pop when not full: count unchanged, order preserved.
- Spurious response (out_r_valid_i with count==0): dropped, no in_r_valid_o, err_o <= 1. err_o clears only on reset.
- Response in the same cycle as the request's own handshake (0-latency slave): not supported. FIFO is empty at that edge, so it counts as spurious.
- Reset mid-operation: FIFO flushed, pointer 0. Responses to pre-reset requests arriving after reset are spurious and set err_o.
- Counter width = $clog2(MaxOutstanding+1). FIFO index width = $clog2(NumIn), min 1.

Decomposition:
- Package tcdm_pkg holds:
  - default AddrWidth/DataWidth localparams;
  - function idx_width(n) returning max(1,$clog2(n));
  - a parametrised typedef for a request bundle (add, wen, wdata, be) used by future TCDM blocks.
- Sub-module tcdm_id_fifo: synchronous FIFO (DEPTH, WIDTH) with push/pop/full/empty/count/head.
  - Push when full and pop when empty are ignored; pop when empty is flagged to the parent.
- Arbiter logic stays inline.

Test Plan:
- Reset, all in_req_i=0 -> out_req_o=0, err_o=0, all in_gnt_o=0; one cycle after rst_i deasserted, still idle.
- NumIn=4, masters 0..3 all request reads continuously, slave gnt=1, r_valid one cycle later -> grant order 0,1,2,3,0; each master receives the rdata for its own address.
- Masters 1 and 3 request, ptr=2 -> master 3 granted first (in_gnt_o=4'b1000), then master 1; responses routed 3 then 1.
- MaxOutstanding=2, slave gnt=1, responses withheld -> exactly 2 handshakes, then out_req_o=0. After one r_valid, out_req_o=1 on the next cycle.
- Same-cycle push and pop at count=1 -> count stays 1; the later response goes to the correct master.
- out_r_valid_i pulse with FIFO empty -> no in_r_valid_o; err_o=1 and held until rst_i. A write with be=4'b0011, wen=0 from master 2 appears unchanged on the out_* ports.

Source files
------------

// File: rtl/tcdm_pkg.sv
// Shared TCDM definitions: default bus widths, index-width helper and a
// request bundle layout for TCDM interconnect blocks.
package tcdm_pkg;

  localparam int unsigned DefaultAddrWidth = 32;
  localparam int unsigned DefaultDataWidth = 32;
  localparam int unsigned DefaultBeWidth   = DefaultDataWidth / 8;

  // Bits needed to index n entries, never less than one bit.
  function automatic int unsigned idx_width(input int unsigned n);
    if (n <= 32'd1) begin
      return 32'd1;
    end else begin
      return int'($clog2(n));
    end
  endfunction

  // Request bundle at the default widths. Blocks built with other widths
  // declare a local struct with the same field order.
  typedef struct packed {
    logic [DefaultAddrWidth-1:0] add;
    logic                        wen;
    logic [DefaultDataWidth-1:0] wdata;
    logic [DefaultBeWidth-1:0]   be;
  } tcdm_req_t;

endpackage

// File: rtl/tcdm_id_fifo.sv
// In-order ID FIFO: remembers which master issued each outstanding request.
// Push while full and pop while empty are ignored; the latter is reported
// on underflow so the parent can flag a response with no owner.
module tcdm_id_fifo
  import tcdm_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 2,
  localparam int unsigned PtrW = idx_width(DEPTH),
  localparam int unsigned CntW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [CntW-1:0]  count,
  output logic [WIDTH-1:0] head,
  output logic             underflow
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PtrW-1:0]  wr_ptr;
  logic [PtrW-1:0]  rd_ptr;
  logic [CntW-1:0]  cnt;
  logic             do_push;
  logic             do_pop;

  // Circular pointer increment that wraps at DEPTH (need not be a power of 2).
  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    if (p == PtrW'(DEPTH - 1)) begin
      return '0;
    end else begin
      return p + PtrW'(1);
    end
  endfunction

  assign full      = (cnt == CntW'(DEPTH));
  assign empty     = (cnt == '0);
  assign do_push   = push & ~full;
  assign do_pop    = pop & ~empty;
  assign underflow = pop & empty;
  assign count     = cnt;
  assign head      = mem[rd_ptr];

  // Pointer and occupancy bookkeeping; push and pop together keep the count.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= ptr_inc(wr_ptr);
      end
      if (do_pop) begin
        rd_ptr <= ptr_inc(rd_ptr);
      end
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + CntW'(1);
        2'b01:   cnt <= cnt - CntW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  // Storage write; contents need no reset because count gates every read.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= wdata;
    end
  end

endmodule

// File: rtl/tcdm_mux_rr.sv
// N-to-1 TCDM multiplexer with round-robin arbitration. Requests pass
// through combinationally; the granted master index is queued so that each
// in-order slave response is steered back to the master that issued it.
module tcdm_mux_rr
  import tcdm_pkg::*;
#(
  parameter int unsigned NumIn          = 4,
  parameter int unsigned AddrWidth      = DefaultAddrWidth,
  parameter int unsigned DataWidth      = DefaultDataWidth,
  parameter int unsigned BeWidth        = DataWidth / 8,
  parameter int unsigned MaxOutstanding = 4
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic [NumIn-1:0]             in_req_i,
  input  logic [NumIn*AddrWidth-1:0]   in_add_i,
  input  logic [NumIn-1:0]             in_wen_i,
  input  logic [NumIn*DataWidth-1:0]   in_wdata_i,
  input  logic [NumIn*BeWidth-1:0]     in_be_i,
  output logic [NumIn-1:0]             in_gnt_o,
  output logic [NumIn*DataWidth-1:0]   in_r_rdata_o,
  output logic [NumIn-1:0]             in_r_opc_o,
  output logic [NumIn-1:0]             in_r_valid_o,
  output logic                         out_req_o,
  output logic [AddrWidth-1:0]         out_add_o,
  output logic                         out_wen_o,
  output logic [DataWidth-1:0]         out_wdata_o,
  output logic [BeWidth-1:0]           out_be_o,
  input  logic                         out_gnt_i,
  input  logic [DataWidth-1:0]         out_r_rdata_i,
  input  logic                         out_r_opc_i,
  input  logic                         out_r_valid_i,
  output logic                         err_o
);

  localparam int unsigned IdxW = idx_width(NumIn);
  localparam int unsigned CntW = $clog2(MaxOutstanding + 1);

  logic [IdxW-1:0] ptr;
  logic [IdxW-1:0] sel;
  logic [IdxW-1:0] head;
  logic [CntW-1:0] outstanding;
  logic            full;
  logic            empty;
  logic            underflow;
  logic            unused_fifo_full;
  logic            handshake;
  logic            rsp_ok;
  logic            err;

  // Master index increment wrapping at NumIn.
  function automatic logic [IdxW-1:0] wrap_inc(input logic [IdxW-1:0] v);
    if (v == IdxW'(NumIn - 1)) begin
      return '0;
    end else begin
      return v + IdxW'(1);
    end
  endfunction

  // Round-robin search: first requesting master at or after ptr, with wrap.
  always_comb begin : rr_search
    logic [IdxW-1:0] cand;
    logic            found;
    sel   = ptr;
    cand  = ptr;
    found = 1'b0;
    for (int i = 0; i < NumIn; i++) begin
      if (!found && in_req_i[cand]) begin
        sel   = cand;
        found = 1'b1;
      end else begin
        found = found;
      end
      cand = wrap_inc(cand);
    end
  end

  // Full is judged on the registered count only, so a response popping in
  // the same cycle never opens room for a new request.
  assign full      = (outstanding == CntW'(MaxOutstanding));
  assign out_req_o = (|in_req_i) & ~full & ~rst_i;
  assign handshake = out_req_o & out_gnt_i;

  assign out_add_o   = in_add_i[sel*AddrWidth +: AddrWidth];
  assign out_wen_o   = in_wen_i[sel];
  assign out_wdata_o = in_wdata_i[sel*DataWidth +: DataWidth];
  assign out_be_o    = in_be_i[sel*BeWidth +: BeWidth];

  // One-hot grant back to the selected master on a handshake.
  always_comb begin
    in_gnt_o = '0;
    if (handshake) begin
      in_gnt_o[sel] = 1'b1;
    end else begin
      in_gnt_o = '0;
    end
  end

  // Priority pointer moves past the winner only when a request is accepted.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ptr <= '0;
    end else if (handshake) begin
      ptr <= wrap_inc(sel);
    end else begin
      ptr <= ptr;
    end
  end

  tcdm_id_fifo #(
    .DEPTH (MaxOutstanding),
    .WIDTH (IdxW)
  ) u_id_fifo (
    .clk       (clk_i),
    .rst       (rst_i),
    .push      (handshake),
    .wdata     (sel),
    .pop       (out_r_valid_i),
    .full      (unused_fifo_full),
    .empty     (empty),
    .count     (outstanding),
    .head      (head),
    .underflow (underflow)
  );

  // A response is only delivered when some request is actually in flight.
  assign rsp_ok       = out_r_valid_i & ~empty & ~rst_i;
  assign in_r_rdata_o = {NumIn{out_r_rdata_i}};

  // Steer response valid and error flag to the master at the FIFO head.
  always_comb begin
    in_r_valid_o = '0;
    in_r_opc_o   = '0;
    if (rsp_ok) begin
      in_r_valid_o[head] = 1'b1;
      in_r_opc_o[head]   = out_r_opc_i;
    end else begin
      in_r_valid_o = '0;
      in_r_opc_o   = '0;
    end
  end

  // Sticky flag for a response that arrives with nothing outstanding.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      err <= 1'b0;
    end else if (underflow) begin
      err <= 1'b1;
    end else begin
      err <= err;
    end
  end

  assign err_o = err;

endmodule

// File: tb/tb_tcdm_mux_rr.sv
// Directed self-checking bench for tcdm_mux_rr (NumIn=4, MaxOutstanding=2).
module tb_tcdm_mux_rr;

  localparam int NI = 4;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int BW = 4;
  localparam int MO = 2;

  logic             clk = 1'b0;
  logic             rst;
  logic [NI-1:0]    in_req;
  logic [NI*AW-1:0] in_add;
  logic [NI-1:0]    in_wen;
  logic [NI*DW-1:0] in_wdata;
  logic [NI*BW-1:0] in_be;
  logic [NI-1:0]    in_gnt;
  logic [NI*DW-1:0] in_r_rdata;
  logic [NI-1:0]    in_r_opc;
  logic [NI-1:0]    in_r_valid;
  logic             out_req;
  logic [AW-1:0]    out_add;
  logic             out_wen;
  logic [DW-1:0]    out_wdata;
  logic [BW-1:0]    out_be;
  logic             out_gnt;
  logic [DW-1:0]    out_r_rdata;
  logic             out_r_opc;
  logic             out_r_valid;
  logic             err;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  tcdm_mux_rr #(
    .NumIn          (NI),
    .AddrWidth      (AW),
    .DataWidth      (DW),
    .MaxOutstanding (MO)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .in_req_i      (in_req),
    .in_add_i      (in_add),
    .in_wen_i      (in_wen),
    .in_wdata_i    (in_wdata),
    .in_be_i       (in_be),
    .in_gnt_o      (in_gnt),
    .in_r_rdata_o  (in_r_rdata),
    .in_r_opc_o    (in_r_opc),
    .in_r_valid_o  (in_r_valid),
    .out_req_o     (out_req),
    .out_add_o     (out_add),
    .out_wen_o     (out_wen),
    .out_wdata_o   (out_wdata),
    .out_be_o      (out_be),
    .out_gnt_i     (out_gnt),
    .out_r_rdata_i (out_r_rdata),
    .out_r_opc_i   (out_r_opc),
    .out_r_valid_i (out_r_valid),
    .err_o         (err)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] addr_of(input int m);
    return 32'h1000_0000 + 32'(m) * 32'h10;
  endfunction

  function automatic logic [31:0] resp_of(input int m);
    return 32'hA5A5_0000 + 32'(m) * 32'h0101;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic slave(input logic gnt, input logic rv, input logic [31:0] rd, input logic opc);
    out_gnt     = gnt;
    out_r_valid = rv;
    out_r_rdata = rd;
    out_r_opc   = opc;
  endtask

  initial begin
    rst    = 1'b1;
    in_req = '0;
    in_wen = '1;
    in_be  = '1;
    in_wdata = '0;
    for (int m = 0; m < NI; m++) begin
      in_add[m*AW +: AW] = addr_of(m);
    end
    slave(1'b0, 1'b0, 32'h0, 1'b0);

    // Reset state, then reset must also mask live requests and responses
    tick();
    check_eq("rst_out_req", out_req, 1'b0);
    check_eq("rst_err", err, 1'b0);
    check_eq("rst_gnt", in_gnt, 4'b0000);
    in_req = 4'b1111;
    slave(1'b1, 1'b1, 32'h1234_5678, 1'b1);
    #1;
    check_eq("rst_mask_req", out_req, 1'b0);
    check_eq("rst_mask_gnt", in_gnt, 4'b0000);
    check_eq("rst_mask_rv", in_r_valid, 4'b0000);
    check_eq("rst_mask_opc", in_r_opc, 4'b0000);
    tick();
    rst    = 1'b0;
    in_req = '0;
    slave(1'b0, 1'b0, 32'h0, 1'b0);
    tick();
    check_eq("idle_out_req", out_req, 1'b0);
    check_eq("idle_err", err, 1'b0);

    // All four masters read continuously, response one cycle after grant
    for (int k = 0; k < 5; k++) begin
      in_req = 4'b1111;
      slave(1'b1, (k > 0), resp_of((k + 3) % 4), 1'b0);
      #1;
      check_eq($sformatf("rr_gnt%0d", k), in_gnt, 64'(1) << (k % 4));
      check_eq($sformatf("rr_add%0d", k), out_add, addr_of(k % 4));
      check_eq($sformatf("rr_rv%0d", k), in_r_valid, (k > 0) ? (64'(1) << ((k + 3) % 4)) : 64'(0));
      check_eq($sformatf("rr_rd%0d", k), in_r_rdata[((k + 3) % 4)*DW +: DW], resp_of((k + 3) % 4));
      tick();
    end
    in_req = '0;
    slave(1'b0, 1'b1, resp_of(0), 1'b0);
    #1;
    check_eq("rr_rv_last", in_r_valid, 4'b0001);
    check_eq("rr_rd_last", in_r_rdata[0 +: DW], resp_of(0));
    tick();
    slave(1'b0, 1'b0, 32'h0, 1'b0);
    #1;
    check_eq("rr_drained", dut.outstanding, 2'd0);

    // Move ptr to 2 via one grant to master 1
    in_req = 4'b0010;
    slave(1'b1, 1'b0, 32'h0, 1'b0);
    #1;
    check_eq("p2_gnt1", in_gnt, 4'b0010);
    tick();
    // Masters 1 and 3 pending but slave stalls: no grant, sel shows master 3
    in_req = 4'b1010;
    slave(1'b0, 1'b1, resp_of(1), 1'b0);
    #1;
    check_eq("p2_stall_req", out_req, 1'b1);
    check_eq("p2_stall_gnt", in_gnt, 4'b0000);
    check_eq("p2_stall_add", out_add, addr_of(3));
    check_eq("p2_stall_rv", in_r_valid, 4'b0010);
    tick();
    slave(1'b1, 1'b0, 32'h0, 1'b0);
    #1;
    check_eq("p2_gnt3", in_gnt, 4'b1000);
    tick();
    in_req = 4'b0010;
    #1;
    check_eq("p2_gnt1b", in_gnt, 4'b0010);
    tick();
    in_req = '0;
    slave(1'b0, 1'b1, resp_of(3), 1'b0);
    #1;
    check_eq("p2_rsp3", in_r_valid, 4'b1000);
    check_eq("p2_rd3", in_r_rdata[3*DW +: DW], resp_of(3));
    tick();
    slave(1'b0, 1'b1, resp_of(1), 1'b0);
    #1;
    check_eq("p2_rsp1", in_r_valid, 4'b0010);
    tick();

    // Fill to MaxOutstanding with responses withheld (ptr is 2)
    in_req = 4'b1111;
    slave(1'b1, 1'b0, 32'h0, 1'b0);
    #1;
    check_eq("full_gnt_a", in_gnt, 4'b0100);
    tick();
    #1;
    check_eq("full_gnt_b", in_gnt, 4'b1000);
    tick();
    #1;
    check_eq("full_req0", out_req, 1'b0);
    check_eq("full_gnt0", in_gnt, 4'b0000);
    tick();
    // Pop while full: still no request this cycle
    slave(1'b1, 1'b1, resp_of(2), 1'b0);
    #1;
    check_eq("full_pop_req", out_req, 1'b0);
    check_eq("full_pop_rv", in_r_valid, 4'b0100);
    tick();
    // Count 1: push (master 0) and pop (master 3) together
    slave(1'b1, 1'b1, resp_of(3), 1'b0);
    #1;
    check_eq("pp_req", out_req, 1'b1);
    check_eq("pp_gnt", in_gnt, 4'b0001);
    check_eq("pp_rv", in_r_valid, 4'b1000);
    tick();
    in_req = '0;
    slave(1'b0, 1'b1, resp_of(0), 1'b1);
    #1;
    check_eq("pp_count", dut.outstanding, 2'd1);
    check_eq("pp_rv0", in_r_valid, 4'b0001);
    check_eq("pp_opc0", in_r_opc, 4'b0001);
    tick();

    // Spurious response with the FIFO empty
    slave(1'b0, 1'b1, 32'hBAD0_BAD0, 1'b1);
    #1;
    check_eq("spur_rv", in_r_valid, 4'b0000);
    check_eq("spur_opc", in_r_opc, 4'b0000);
    tick();
    slave(1'b0, 1'b0, 32'h0, 1'b0);
    #1;
    check_eq("spur_err", err, 1'b1);

    // Write from master 2 passes through unchanged (slave stalls)
    in_req = 4'b0100;
    in_wen[2] = 1'b0;
    in_be[2*BW +: BW] = 4'b0011;
    in_wdata[2*DW +: DW] = 32'hDEAD_BEEF;
    #1;
    check_eq("wr_req", out_req, 1'b1);
    check_eq("wr_wen", out_wen, 1'b0);
    check_eq("wr_be", out_be, 4'b0011);
    check_eq("wr_wdata", out_wdata, 32'hDEAD_BEEF);
    check_eq("wr_add", out_add, addr_of(2));
    tick();
    check_eq("err_held", err, 1'b1);
    in_req = '0;
    in_wen = '1;
    in_be  = '1;

    // Reset mid-operation: outstanding request lost, late response is spurious
    in_req = 4'b0001;
    slave(1'b1, 1'b0, 32'h0, 1'b0);
    #1;
    check_eq("mid_gnt", in_gnt, 4'b0001);
    tick();
    in_req = '0;
    slave(1'b0, 1'b0, 32'h0, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_eq("mid_err_clr", err, 1'b0);
    slave(1'b0, 1'b1, resp_of(0), 1'b0);
    #1;
    check_eq("mid_late_rv", in_r_valid, 4'b0000);
    tick();
    slave(1'b0, 1'b0, 32'h0, 1'b0);
    #1;
    check_eq("mid_late_err", err, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
